bitonic_frame_packer: RTL and testbench
=======================================

Name: bitonic_frame_packer

Overview:
- Producer-side front end for the bitonic sorting network.
- Accepts a scalar element stream with valid/ready handshake and packs 2**LOG_INPUT_NUM elements into the sorter's flat input vector.
- Pulses x_valid once per frame; a short frame (in_last or idle timeout) is padded with a sentinel that sorts to the tail.
- Reports the real element count alongside each frame.

Parameters:
- LOG_INPUT_NUM, 4, log2 of elements per frame; N = 2**LOG_INPUT_NUM, must be >= 1.
- DATA_WIDTH, 8, bits per element.
- SIGNED, 0, 1 = elements are two's complement; selects the sentinel value.
- ASCENDING, 1, must match the sorter's direction; selects the sentinel value.
- FLUSH_TIMEOUT, 0, idle cycles before a partial frame auto-closes; 0 = disabled.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- in_data  input  DATA_WIDTH  stream element.
- in_valid  input  1  in_data valid.
- in_last  input  1  marks the final element of a frame; qualified by in_valid.
- in_ready  output  1  packer can accept; tied high outside reset.
- x  output  DATA_WIDTH*N  packed frame; slot k occupies bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k].
- x_valid  output  1  one-cycle pulse; x and x_count are valid.
- x_count  output  LOG_INPUT_NUM+1  number of real (non-pad) elements in x, 1..N.

Behaviour:
- Reset (rst low, asynchronous):
  - x = 0, x_valid = 0, x_count = 0, in_ready = 0.
  - Fill counter, slot mask and idle timer cleared.
  - A partial frame in progress is discarded.
  - in_ready rises on the first clk edge after rst deasserts.
- Accept: an element transfers on a rising edge with in_valid && in_ready.
  - It is written to slot cnt of the working buffer, slot-mask bit cnt is set, and cnt increments.
  - Slot 0 receives the first accepted element of a frame.
- Frame close happens on the accepting edge when either:
  - cnt == N-1, i.e. this element fills slot N-1; or
  - in_last = 1.
  - in_last on the Nth element is a single close, not two.
- On the closing edge:
  - x is loaded from the working buffer with every unmasked slot replaced by the sentinel.
  - x_count = accepted count (N for a full frame).
  - x_valid = 1 for exactly the next cycle.
  - Working buffer mask and cnt clear on the same edge.
- Latency: x_valid is high in the cycle following the closing acceptance edge (1 cycle).
- x and x_count hold their values until the next close. x_valid is otherwise 0.
- Throughput: double-buffered, so in_ready stays 1 and an element may be accepted in the same cycle x_valid is high.
  - Back-to-back full frames are emitted every N cycles with no bubble.
- The sorter has no backpressure, so the packer has no output stall and no overflow condition.
- Sentinel values:
  - ASCENDING=1, SIGNED=0: all ones.
  - ASCENDING=1, SIGNED=1: 0 followed by ones (max positive).
  - ASCENDING=0, SIGNED=0: all zeros.
  - ASCENDING=0, SIGNED=1: 1 followed by zeros (most negative).
- Idle timeout (FLUSH_TIMEOUT > 0):
  - The timer counts cycles with cnt > 0 and no acceptance; it is held at 0 while cnt == 0.
  - When the timer reaches FLUSH_TIMEOUT, the frame closes exactly as an in_last close, and the timer clears.
  - Any acceptance resets the timer to 0.
  - An acceptance in the same cycle the timer expires takes priority: the element joins the frame and no timeout close occurs.
- in_last with in_valid low is ignored. Empty frames are never emitted.
- Timer width: clog2(FLUSH_TIMEOUT+1), minimum 1 bit.

Test Plan:
- Full ascending frame: N=4, DW=8, SIGNED=0, stream 9,3,7,1 with in_last=0 → one cycle after the 4th acceptance, x_valid=1, x=0x01070309, x_count=4. Pulse lasts 1 cycle only.
- Short frame: stream 5,2 with in_last on 2, ASCENDING=1, SIGNED=0 → x=0xFFFF0205, x_count=2. Repeat with ASCENDING=0, SIGNED=1 → x=0x80800205.
- Back-to-back: 12 continuous elements 0..11 with in_valid held high → in_ready never drops; x_valid pulses at 4-cycle spacing with x=0x03020100, 0x07060504, 0x0B0A0908.
- Timeout: FLUSH_TIMEOUT=3, stream single 0x44 then idle → x_valid exactly 4 cycles after acceptance, x=0xFFFFFF44, x_count=1. Acceptance on the expiry cycle yields no close.
- Reset mid-frame: accept 2 elements, pulse rst low asynchronously, release, then stream 1,2,3,4 → all outputs 0 during reset; next frame x=0x04030201, x_count=4, no stale data.
- Signed boundary: SIGNED=1, ASCENDING=1, stream 0x80 with in_last → x=0x7F7F7F80, x_count=1.

Source files
------------

// File: rtl/bitonic_frame_packer.sv
// Packs a valid/ready scalar stream into 2**LOG_INPUT_NUM-wide frames for the
// bitonic sorter, padding short frames with a sentinel that sorts to the tail.
module bitonic_frame_packer #(
  parameter int LOG_INPUT_NUM = 4,
  parameter int DATA_WIDTH    = 8,
  parameter bit SIGNED        = 1'b0,
  parameter bit ASCENDING     = 1'b1,
  parameter int FLUSH_TIMEOUT = 0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [DATA_WIDTH-1:0]                   in_data,
  input  logic                                    in_valid,
  input  logic                                    in_last,
  output logic                                    in_ready,
  output logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0] x,
  output logic                                    x_valid,
  output logic [LOG_INPUT_NUM:0]                  x_count
);

  localparam int N          = 2 ** LOG_INPUT_NUM;
  localparam bit TIMEOUT_EN = (FLUSH_TIMEOUT > 0);
  localparam int TW         = TIMEOUT_EN ? $clog2(FLUSH_TIMEOUT + 1) : 1;

  localparam logic [LOG_INPUT_NUM-1:0] LAST_SLOT   = LOG_INPUT_NUM'(N - 1);
  localparam logic [TW-1:0]            TIMER_LIMIT = TW'(FLUSH_TIMEOUT);

  // Padding must land after every real element once the sorter runs.
  localparam logic [DATA_WIDTH-1:0] SENTINEL =
    ASCENDING ? (SIGNED ? {1'b0, {(DATA_WIDTH-1){1'b1}}} : {DATA_WIDTH{1'b1}})
              : (SIGNED ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {DATA_WIDTH{1'b0}});

  logic                                  ready_q;
  logic [N-1:0][DATA_WIDTH-1:0]          buf_q, buf_d;
  logic [N-1:0]                          mask_q, mask_d;
  logic [LOG_INPUT_NUM-1:0]              fillCnt_q, fillCnt_d;
  logic [TW-1:0]                         timer_q, timer_d;
  logic [N-1:0][DATA_WIDTH-1:0]          x_q, x_d;
  logic                                  xValid_q, xValid_d;
  logic [LOG_INPUT_NUM:0]                xCount_q, xCount_d;

  logic                                  accept;
  logic                                  acceptClose;
  logic                                  timeoutClose;
  logic [LOG_INPUT_NUM:0]                fillExt;

  assign accept       = in_valid && ready_q;
  assign acceptClose  = accept && ((fillCnt_q == LAST_SLOT) || in_last);
  assign timeoutClose = TIMEOUT_EN && !accept && (fillCnt_q != '0) &&
                        (timer_q == TIMER_LIMIT);
  assign fillExt      = {1'b0, fillCnt_q};

  // The output register acts as the second buffer, so the working buffer is
  // free to take a new element on the very edge it hands a frame over.
  always_comb begin
    buf_d     = buf_q;
    mask_d    = mask_q;
    fillCnt_d = fillCnt_q;
    timer_d   = timer_q;
    x_d       = x_q;
    xCount_d  = xCount_q;
    xValid_d  = 1'b0;

    if (accept) begin
      buf_d[fillCnt_q]  = in_data;
      mask_d[fillCnt_q] = 1'b1;
      fillCnt_d         = fillCnt_q + LOG_INPUT_NUM'(1);
    end

    if (acceptClose || timeoutClose) begin
      for (int k = 0; k < N; k++) begin
        x_d[k] = mask_d[k] ? buf_d[k] : SENTINEL;
      end
      xCount_d  = accept ? fillExt + (LOG_INPUT_NUM+1)'(1) : fillExt;
      xValid_d  = 1'b1;
      mask_d    = '0;
      fillCnt_d = '0;
    end

    // An acceptance on the expiry cycle wins, so it simply restarts the timer.
    if (!TIMEOUT_EN || accept || (fillCnt_q == '0) || timeoutClose) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q   <= 1'b0;
      buf_q     <= '0;
      mask_q    <= '0;
      fillCnt_q <= '0;
      timer_q   <= '0;
      x_q       <= '0;
      xValid_q  <= 1'b0;
      xCount_q  <= '0;
    end else begin
      ready_q   <= 1'b1;
      buf_q     <= buf_d;
      mask_q    <= mask_d;
      fillCnt_q <= fillCnt_d;
      timer_q   <= timer_d;
      x_q       <= x_d;
      xValid_q  <= xValid_d;
      xCount_q  <= xCount_d;
    end
  end

  assign in_ready = ready_q;
  assign x        = x_q;
  assign x_valid  = xValid_q;
  assign x_count  = xCount_q;

endmodule

// File: tb/tb_bitonic_frame_packer.sv
// Self-checking bench for bitonic_frame_packer: four N=4 instances covering the
// sentinel variants and the idle timeout, checked through a frame scoreboard.
module tb_bitonic_frame_packer;

  localparam int LOG = 2;
  localparam int DW  = 8;

  typedef struct {
    int               n;
    logic [3:0][7:0]  d;
    logic             lastOnEnd;
    logic [31:0]      xMain;
    logic [31:0]      xDesc;
    logic [31:0]      xSasc;
    logic [2:0]       count;
  } vec_t;

  typedef struct {
    logic [31:0] xMain;
    logic [31:0] xDesc;
    logic [31:0] xSasc;
    logic [2:0]  count;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  inData = '0;
  logic        inValid = 1'b0;
  logic        inLast = 1'b0;
  logic        tOnly = 1'b0;
  logic        mainIn;

  logic        mainReady, descReady, sascReady, tmoReady;
  logic [31:0] mainX, descX, sascX, tmoX;
  logic        mainValid, descValid, sascValid, tmoValid;
  logic [2:0]  mainCount, descCount, sascCount, tmoCount;

  int   testsRun = 0;
  int   testsFailed = 0;
  int   cyc = 0;
  exp_t expQ[$];
  int   pulseCyc[$];
  vec_t vecs[9];

  assign mainIn = inValid & ~tOnly;

  bitonic_frame_packer #(.LOG_INPUT_NUM(LOG), .DATA_WIDTH(DW), .SIGNED(1'b0),
                         .ASCENDING(1'b1), .FLUSH_TIMEOUT(0)) u_main (
    .clk(clk), .rst(rst), .in_data(inData), .in_valid(mainIn), .in_last(inLast),
    .in_ready(mainReady), .x(mainX), .x_valid(mainValid), .x_count(mainCount));

  bitonic_frame_packer #(.LOG_INPUT_NUM(LOG), .DATA_WIDTH(DW), .SIGNED(1'b1),
                         .ASCENDING(1'b0), .FLUSH_TIMEOUT(0)) u_desc (
    .clk(clk), .rst(rst), .in_data(inData), .in_valid(mainIn), .in_last(inLast),
    .in_ready(descReady), .x(descX), .x_valid(descValid), .x_count(descCount));

  bitonic_frame_packer #(.LOG_INPUT_NUM(LOG), .DATA_WIDTH(DW), .SIGNED(1'b1),
                         .ASCENDING(1'b1), .FLUSH_TIMEOUT(0)) u_sasc (
    .clk(clk), .rst(rst), .in_data(inData), .in_valid(mainIn), .in_last(inLast),
    .in_ready(sascReady), .x(sascX), .x_valid(sascValid), .x_count(sascCount));

  bitonic_frame_packer #(.LOG_INPUT_NUM(LOG), .DATA_WIDTH(DW), .SIGNED(1'b0),
                         .ASCENDING(1'b1), .FLUSH_TIMEOUT(3)) u_tmo (
    .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid), .in_last(inLast),
    .in_ready(tmoReady), .x(tmoX), .x_valid(tmoValid), .x_count(tmoCount));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every main-instance frame must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mainValid) begin
      pulseCyc.push_back(cyc);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_frame", mainX, 32'hDEADBEEF);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("x_asc_unsigned", mainX, e.xMain);
        checkOutput("x_desc_signed", descX, e.xDesc);
        checkOutput("x_asc_signed", sascX, e.xSasc);
        checkOutput("x_count", 32'(mainCount), 32'(e.count));
        checkOutput("x_count_desc", 32'(descCount), 32'(e.count));
        checkOutput("x_valid_desc", 32'(descValid), 32'd1);
        checkOutput("x_valid_sasc", 32'(sascValid), 32'd1);
      end
    end
  end

  task automatic sendElem(input logic [7:0] d, input logic last);
    @(negedge clk);
    inData  = d;
    inValid = 1'b1;
    inLast  = last;
  endtask

  task automatic idle();
    @(negedge clk);
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic applyStimulus(input int idx);
    exp_t e;
    e.xMain = vecs[idx].xMain;
    e.xDesc = vecs[idx].xDesc;
    e.xSasc = vecs[idx].xSasc;
    e.count = vecs[idx].count;
    expQ.push_back(e);
    for (int i = 0; i < vecs[idx].n; i++) begin
      sendElem(vecs[idx].d[i], vecs[idx].lastOnEnd && (i == vecs[idx].n - 1));
      checkOutput("in_ready_high", 32'(mainReady), 32'd1);
    end
  endtask

  task automatic setVec(input int idx, input int n, input logic [31:0] d, input logic last,
                        input logic [31:0] xm, input logic [31:0] xd, input logic [31:0] xs,
                        input logic [2:0] cnt);
    vecs[idx].n         = n;
    vecs[idx].d         = d;
    vecs[idx].lastOnEnd = last;
    vecs[idx].xMain     = xm;
    vecs[idx].xDesc     = xd;
    vecs[idx].xSasc     = xs;
    vecs[idx].count     = cnt;
  endtask

  // Drives one timeout-instance scenario and reports the first pulse.
  task automatic runTimeout(input logic [7:0] first, input int lateK, input logic [7:0] late,
                            input int maxK, output int pulses, output int firstK,
                            output logic [31:0] px, output logic [2:0] pc);
    pulses = 0;
    firstK = -1;
    px     = '0;
    pc     = '0;
    sendElem(first, 1'b0);
    for (int k = 1; k <= maxK; k++) begin
      @(negedge clk);
      if (tmoValid) begin
        pulses++;
        if (firstK < 0) begin
          firstK = k;
          px     = tmoX;
          pc     = tmoCount;
        end
      end
      if (k == lateK) begin
        inData  = late;
        inValid = 1'b1;
      end else begin
        inValid = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses, firstK;
    logic [31:0] px;
    logic [2:0]  pc;

    setVec(0, 4, 32'h01070309, 1'b0, 32'h01070309, 32'h01070309, 32'h01070309, 3'd4);
    setVec(1, 2, 32'h00000205, 1'b1, 32'hFFFF0205, 32'h80800205, 32'h7F7F0205, 3'd2);
    setVec(2, 1, 32'h00000080, 1'b1, 32'hFFFFFF80, 32'h80808080, 32'h7F7F7F80, 3'd1);
    setVec(3, 3, 32'h00C3B2A1, 1'b1, 32'hFFC3B2A1, 32'h80C3B2A1, 32'h7FC3B2A1, 3'd3);
    setVec(4, 4, 32'hAABBCCDD, 1'b1, 32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD, 3'd4);
    setVec(5, 4, 32'h03020100, 1'b0, 32'h03020100, 32'h03020100, 32'h03020100, 3'd4);
    setVec(6, 4, 32'h07060504, 1'b0, 32'h07060504, 32'h07060504, 32'h07060504, 3'd4);
    setVec(7, 4, 32'h0B0A0908, 1'b0, 32'h0B0A0908, 32'h0B0A0908, 32'h0B0A0908, 3'd4);
    setVec(8, 4, 32'h04030201, 1'b0, 32'h04030201, 32'h04030201, 32'h04030201, 3'd4);

    #3;
    checkOutput("reset_x", mainX, 32'h0);
    checkOutput("reset_x_valid", 32'(mainValid), 32'd0);
    checkOutput("reset_x_count", 32'(mainCount), 32'd0);
    checkOutput("reset_in_ready", 32'(mainReady), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Full frame, then confirm the pulse is exactly one cycle wide.
    applyStimulus(0);
    idle();
    checkOutput("pulse_high", 32'(mainValid), 32'd1);
    @(negedge clk);
    checkOutput("pulse_low", 32'(mainValid), 32'd0);

    for (int r = 1; r <= 4; r++) begin
      applyStimulus(r);
      idle();
      @(negedge clk);
    end

    // Back-to-back full frames with in_valid held high throughout.
    pulseCyc.delete();
    for (int r = 5; r <= 7; r++) applyStimulus(r);
    idle();
    repeat (3) @(negedge clk);
    checkOutput("b2b_pulses", 32'(pulseCyc.size()), 32'd3);
    if (pulseCyc.size() == 3) begin
      checkOutput("b2b_spacing_1", 32'(pulseCyc[1] - pulseCyc[0]), 32'd4);
      checkOutput("b2b_spacing_2", 32'(pulseCyc[2] - pulseCyc[1]), 32'd4);
    end

    // in_last without in_valid in the middle of a frame must not close it.
    begin
      exp_t e;
      e.xMain = vecs[3].xMain;
      e.xDesc = vecs[3].xDesc;
      e.xSasc = vecs[3].xSasc;
      e.count = vecs[3].count;
      expQ.push_back(e);
    end
    sendElem(8'hA1, 1'b0);
    @(negedge clk);
    inValid = 1'b0;
    inLast  = 1'b1;
    sendElem(8'hB2, 1'b0);
    sendElem(8'hC3, 1'b1);
    idle();
    @(negedge clk);

    // Asynchronous reset in the middle of a partial frame.
    sendElem(8'h55, 1'b0);
    sendElem(8'h66, 1'b0);
    @(negedge clk);
    inValid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("midreset_x", mainX, 32'h0);
    checkOutput("midreset_x_valid", 32'(mainValid), 32'd0);
    checkOutput("midreset_x_count", 32'(mainCount), 32'd0);
    checkOutput("midreset_in_ready", 32'(mainReady), 32'd0);
    checkOutput("midreset_x_desc", descX, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("ready_before_edge", 32'(mainReady), 32'd0);
    applyStimulus(8);
    idle();
    @(negedge clk);

    // Idle timeout: single element closes 4 cycles after its acceptance.
    tOnly = 1'b1;
    runTimeout(8'h44, -1, 8'h00, 8, pulses, firstK, px, pc);
    checkOutput("tmo_pulses", 32'(pulses), 32'd1);
    checkOutput("tmo_latency", 32'(firstK), 32'd5);
    checkOutput("tmo_x", px, 32'hFFFFFF44);
    checkOutput("tmo_count", 32'(pc), 32'd1);

    // Acceptance on the expiry cycle joins the frame and restarts the timer.
    runTimeout(8'h11, 4, 8'h22, 11, pulses, firstK, px, pc);
    checkOutput("expiry_pulses", 32'(pulses), 32'd1);
    checkOutput("expiry_latency", 32'(firstK), 32'd9);
    checkOutput("expiry_x", px, 32'hFFFF2211);
    checkOutput("expiry_count", 32'(pc), 32'd2);
    tOnly = 1'b0;

    for (int w = 0; w < 20 && expQ.size() > 0; w++) @(negedge clk);
    checkOutput("scoreboard_drain", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
